// File: rtl/alu_seq_if.sv
// ============================================================================
// Module   : alu_seq_if
// Brief    : Operand/opcode request and result/flag response bundle for alu_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_seq_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [3:0]           op;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic [WIDTH-1:0]     remainder;
    logic                 cout;
    logic                 borrow;
    logic                 a_greater;
    logic                 a_equal;
    logic                 a_less;
    logic                 div_by_zero;
    logic                 busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, remainder, cout, borrow,
               a_greater, a_equal, a_less, div_by_zero, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, remainder, cout, borrow,
               a_greater, a_equal, a_less, div_by_zero, busy
    );
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module   : alu_seq
// Brief    : Registered ALU with valid/ready handshake, iterative mul and div.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_seq #(
    parameter int WIDTH = 4
) (
    input  wire            clk,
    input  wire            rst_n,
    alu_seq_if.slave       bus
);
    localparam int c_CW = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_AND = 4'b0010;
    localparam logic [3:0] c_OP_OR  = 4'b0011;
    localparam logic [3:0] c_OP_XOR = 4'b0100;
    localparam logic [3:0] c_OP_EQ  = 4'b0101;
    localparam logic [3:0] c_OP_MUL = 4'b0110;
    localparam logic [3:0] c_OP_DIV = 4'b0111;
    localparam logic [3:0] c_OP_SHL = 4'b1000;
    localparam logic [3:0] c_OP_SHR = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_x;      // multiplicand, shifted left each step
    logic [WIDTH-1:0]     r_y;      // multiplier (mul) or dividend/quotient (div)
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_rem;
    logic                 r_in_ready, r_out_valid, r_busy;
    logic [2*WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]     r_remainder;
    logic                 r_cout, r_borrow, r_agt, r_aeq, r_alt, r_dbz;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_a_ext;
    logic [2*WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]     w_rem;
    logic                 w_cout, w_borrow, w_dbz;
    logic [2*WIDTH-1:0]   w_acc_nx;
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_nx;
    logic [WIDTH-1:0]     w_q_nx;

    assign w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff  = bus.a - bus.b;
    assign w_a_ext = {{WIDTH{1'b0}}, bus.a};

    always_comb begin
        w_res    = '0;
        w_rem    = '0;
        w_cout   = 1'b0;
        w_borrow = 1'b0;
        w_dbz    = 1'b0;
        case (bus.op)
            c_OP_ADD: begin
                w_res  = {{(WIDTH-1){1'b0}}, w_sum};
                w_cout = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_res    = {{WIDTH{1'b0}}, w_diff};
                w_borrow = (bus.a < bus.b);
            end
            c_OP_AND: w_res = {{WIDTH{1'b0}}, bus.a & bus.b};
            c_OP_OR:  w_res = {{WIDTH{1'b0}}, bus.a | bus.b};
            c_OP_XOR: w_res = {{WIDTH{1'b0}}, bus.a ^ bus.b};
            c_OP_EQ:  w_res = {{(2*WIDTH-1){1'b0}}, (bus.a == bus.b)};
            c_OP_DIV: begin
                // Only reaches DONE from here when b == 0
                if (bus.b == '0) begin
                    w_res = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                    w_rem = bus.a;
                    w_dbz = 1'b1;
                end
            end
            c_OP_SHL: w_res = (32'(bus.b) >= 2*WIDTH) ? '0 : (w_a_ext << bus.b);
            c_OP_SHR: w_res = (32'(bus.b) >= WIDTH)   ? '0 : (w_a_ext >> bus.b);
            default:  w_res = '0;
        endcase
    end

    assign w_acc_nx = r_acc + (r_y[0] ? r_x : '0);

    // Restoring step: partial remainder stays below b, so the difference fits WIDTH bits
    assign w_shift  = {r_rem, r_y[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_b});
    assign w_rem_nx = w_ge ? (w_shift[WIDTH-1:0] - r_b) : w_shift[WIDTH-1:0];
    assign w_q_nx   = {r_y[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= '0;
            r_remainder <= '0;
            r_cout      <= 1'b0;
            r_borrow    <= 1'b0;
            r_agt       <= 1'b0;
            r_aeq       <= 1'b0;
            r_alt       <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready  <= 1'b0;
                        r_cnt       <= '0;
                        r_acc       <= '0;
                        r_rem       <= '0;
                        r_x         <= w_a_ext;
                        r_b         <= bus.b;
                        r_agt       <= (bus.a > bus.b);
                        r_aeq       <= (bus.a == bus.b);
                        r_alt       <= (bus.a < bus.b);
                        r_result    <= w_res;
                        r_remainder <= w_rem;
                        r_cout      <= w_cout;
                        r_borrow    <= w_borrow;
                        r_dbz       <= w_dbz;
                        if (bus.op == c_OP_MUL) begin
                            r_y     <= bus.b;
                            r_busy  <= 1'b1;
                            r_state <= S_MUL;
                        end else if (bus.op == c_OP_DIV && bus.b != '0) begin
                            r_y     <= bus.a;
                            r_busy  <= 1'b1;
                            r_state <= S_DIV;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_nx;
                    r_x   <= r_x << 1;
                    r_y   <= r_y >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_result    <= w_acc_nx;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_y   <= w_q_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_result    <= {{WIDTH{1'b0}}, w_q_nx};
                        r_remainder <= w_rem_nx;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.busy        = r_busy;
    assign bus.result      = r_result;
    assign bus.remainder   = r_remainder;
    assign bus.cout        = r_cout;
    assign bus.borrow      = r_borrow;
    assign bus.a_greater   = r_agt;
    assign bus.a_equal     = r_aeq;
    assign bus.a_less      = r_alt;
    assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Directed self-checking bench for alu_seq at WIDTH=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq;
    localparam int c_W = 4;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    alu_seq_if #(.WIDTH(c_W)) u_if ();

    alu_seq #(.WIDTH(c_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {16'd0, u_if.out_valid, u_if.busy, u_if.result, u_if.remainder,
                u_if.cout, u_if.borrow, u_if.a_greater, u_if.a_equal,
                u_if.a_less, u_if.div_by_zero};
    endfunction

    // Issue one op, check latency, busy count, result and flags, then release
    task automatic run_vec(input string nm, input logic [3:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [7:0] res, input logic [3:0] rem,
                           input logic [5:0] flg, input int lat, input int bsy);
        int n_lat;
        int n_busy;
        @(negedge clk);
        chk({nm, "_inrdy"}, 32'(u_if.in_ready), 32'd1);
        u_if.in_valid = 1'b1;
        u_if.op = op;
        u_if.a = a;
        u_if.b = b;
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        u_if.a = 4'($urandom);
        u_if.b = 4'($urandom);
        u_if.op = 4'($urandom);
        n_lat = 0;
        n_busy = 0;
        do begin
            @(negedge clk);
            n_lat++;
            if (u_if.busy) n_busy++;
        end while (!u_if.out_valid && n_lat < 40);
        chk({nm, "_lat"}, 32'(n_lat), 32'(lat));
        chk({nm, "_busy"}, 32'(n_busy), 32'(bsy));
        chk({nm, "_res"}, 32'(u_if.result), 32'(res));
        chk({nm, "_rem"}, 32'(u_if.remainder), 32'(rem));
        chk({nm, "_flags"}, 32'({u_if.cout, u_if.borrow, u_if.a_greater, u_if.a_equal,
                                 u_if.a_less, u_if.div_by_zero}), 32'(flg));
        u_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        u_if.out_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_rel"}, 32'({u_if.in_ready, u_if.out_valid}), 32'b10);
    endtask

    initial begin
        n_total = 0;
        n_bad = 0;
        rst_n = 1'b0;
        u_if.in_valid = 1'b0;
        u_if.out_ready = 1'b0;
        u_if.a = '0;
        u_if.b = '0;
        u_if.op = '0;
        repeat (2) @(negedge clk);
        chk("rst_outs", all_outs(), 32'd0);
        chk("rst_inrdy", 32'(u_if.in_ready), 32'd1);
        rst_n = 1'b1;

        // flags: {cout, borrow, a_greater, a_equal, a_less, div_by_zero}
        run_vec("add98",  4'h0, 4'd9,  4'd8, 8'h11, 4'd0, 6'b101000, 1, 0);
        run_vec("sub35",  4'h1, 4'd3,  4'd5, 8'h0E, 4'd0, 6'b010010, 1, 0);
        run_vec("sub55",  4'h1, 4'd5,  4'd5, 8'h00, 4'd0, 6'b000100, 1, 0);
        run_vec("eq77",   4'h5, 4'd7,  4'd7, 8'h01, 4'd0, 6'b000100, 1, 0);
        run_vec("addFF",  4'h0, 4'hF,  4'hF, 8'h1E, 4'd0, 6'b100100, 1, 0);
        run_vec("andCA",  4'h2, 4'hC,  4'hA, 8'h08, 4'd0, 6'b001000, 1, 0);
        run_vec("orCA",   4'h3, 4'hC,  4'hA, 8'h0E, 4'd0, 6'b001000, 1, 0);
        run_vec("xorCA",  4'h4, 4'hC,  4'hA, 8'h06, 4'd0, 6'b001000, 1, 0);
        run_vec("mulFF",  4'h6, 4'hF,  4'hF, 8'hE1, 4'd0, 6'b000100, 5, 4);
        run_vec("mulDB",  4'h6, 4'hD,  4'hB, 8'h8F, 4'd0, 6'b001000, 5, 4);
        run_vec("mul09",  4'h6, 4'h0,  4'h9, 8'h00, 4'd0, 6'b000010, 5, 4);
        run_vec("div134", 4'h7, 4'd13, 4'd4, 8'h03, 4'd1, 6'b001000, 5, 4);
        run_vec("divF1",  4'h7, 4'hF,  4'd1, 8'h0F, 4'd0, 6'b001000, 5, 4);
        run_vec("div37",  4'h7, 4'd3,  4'd7, 8'h00, 4'd3, 6'b000010, 5, 4);
        run_vec("div60",  4'h7, 4'd6,  4'd0, 8'h0F, 4'd6, 6'b001001, 1, 0);
        run_vec("shlF3",  4'h8, 4'hF,  4'd3, 8'h78, 4'd0, 6'b001000, 1, 0);
        run_vec("shl17",  4'h8, 4'h1,  4'd7, 8'h80, 4'd0, 6'b000010, 1, 0);
        run_vec("shl18",  4'h8, 4'h1,  4'd8, 8'h00, 4'd0, 6'b000010, 1, 0);
        run_vec("shrF5",  4'h9, 4'hF,  4'd5, 8'h00, 4'd0, 6'b001000, 1, 0);
        run_vec("shr83",  4'h9, 4'h8,  4'd3, 8'h01, 4'd0, 6'b001000, 1, 0);
        run_vec("shr84",  4'h9, 4'h8,  4'd4, 8'h00, 4'd0, 6'b001000, 1, 0);
        run_vec("rsvd",   4'hF, 4'd5,  4'd9, 8'h00, 4'd0, 6'b000010, 1, 0);

        // Backpressure: mul 7*6 held for 10 cycles
        @(negedge clk);
        u_if.in_valid = 1'b1;
        u_if.op = 4'h6;
        u_if.a = 4'd7;
        u_if.b = 4'd6;
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        u_if.a = 4'd1;
        repeat (c_W + 1) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp%0d", k), 32'({u_if.out_valid, u_if.in_ready, u_if.result}),
                32'({1'b1, 1'b0, 8'h2A}));
            @(negedge clk);
        end
        u_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        u_if.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_rel", 32'({u_if.in_ready, u_if.out_valid}), 32'b10);

        // Reset in the middle of a divide
        @(negedge clk);
        u_if.in_valid = 1'b1;
        u_if.op = 4'h7;
        u_if.a = 4'd13;
        u_if.b = 4'd4;
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", 32'(u_if.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", all_outs(), 32'd0);
        chk("mid_rst_inrdy", 32'(u_if.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int n_ov;
            n_ov = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (u_if.out_valid) n_ov++;
            end
            chk("mid_no_ov", 32'(n_ov), 32'd0);
        end
        run_vec("post_add", 4'h0, 4'd9, 4'd8, 8'h11, 4'd0, 6'b101000, 1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
